// File: rtl/fwrisc_mds_arbiter_if.sv
// Handshake bundle between two requesters, the shared mul/div/shift unit and the arbiter.
//   slave  : arbiter side (consumes requests and unit results, drives grants/responses/issue)
//   master : environment side (requesters and the unit)
// Requester i uses lane i of every packed request/response vector.
interface fwrisc_mds_arbiter_if;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [7:0]  req_op;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [31:0] mds_in_a;
  logic [31:0] mds_in_b;
  logic [3:0]  mds_op;
  logic        mds_in_valid;
  logic [31:0] mds_out;
  logic        mds_out_valid;

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready, mds_out, mds_out_valid,
    output req_ready, rsp_valid, rsp_data, rsp_err, mds_in_a, mds_in_b, mds_op, mds_in_valid
  );

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready, mds_out, mds_out_valid,
    input  req_ready, rsp_valid, rsp_data, rsp_err, mds_in_a, mds_in_b, mds_op, mds_in_valid
  );
endinterface

// File: rtl/fwrisc_mds_arbiter.sv
// Round-robin arbiter sharing one multi-cycle mul/div/shift unit between two requesters.
// One operation is outstanding at a time: the winner's operands are registered, issued with a
// one-cycle mds_in_valid pulse, and the unit result (or a watchdog error) is held on rsp_* for
// the owning requester until it is accepted.
// Ports:
//   clock  : rising-edge clock
//   reset  : asynchronous active-low reset
//   bus_io : request/response/unit handshake bundle (arbiter side)
module fwrisc_mds_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter bit          ENABLE_TIMEOUT = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  fwrisc_mds_arbiter_if.slave   bus_io
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q;
  logic        last_grant_q;
  logic        owner_q;
  logic [7:0]  cnt_q;
  logic [31:0] in_a_q;
  logic [31:0] in_b_q;
  logic [3:0]  op_q;
  logic        in_valid_q;
  logic [1:0]  rsp_valid_q;
  logic [31:0] rsp_data_q;
  logic        rsp_err_q;

  logic        sel;
  logic        accept;
  logic        timeout_hit;
  logic [1:0]  req_ready;

  always_comb begin
    // A lone requester wins outright; on contention the one not granted last time wins.
    case (bus_io.req_valid)
      2'b01:   sel = 1'b0;
      2'b10:   sel = 1'b1;
      default: sel = ~last_grant_q;
    endcase
    // Ready is only offered to a requester that is actually asking, so an idle bus shows 0.
    accept    = (state_q == StIdle) && (|bus_io.req_valid);
    req_ready = 2'b00;
    if (accept) req_ready[sel] = 1'b1;
    timeout_hit = ENABLE_TIMEOUT && (cnt_q == TimeoutLast);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      cnt_q        <= '0;
      in_a_q       <= '0;
      in_b_q       <= '0;
      op_q         <= '0;
      in_valid_q   <= 1'b0;
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      in_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // Unit strobes seen here are stale and deliberately ignored.
          if (accept) begin
            op_q         <= sel ? bus_io.req_op[7:4]   : bus_io.req_op[3:0];
            in_a_q       <= sel ? bus_io.req_a[63:32]  : bus_io.req_a[31:0];
            in_b_q       <= sel ? bus_io.req_b[63:32]  : bus_io.req_b[31:0];
            owner_q      <= sel;
            last_grant_q <= sel;
            in_valid_q   <= 1'b1;
            state_q      <= StIssue;
          end
        end
        StIssue: begin
          cnt_q   <= '0;
          state_q <= StWait;
        end
        StWait: begin
          // The unit strobe takes priority over a watchdog expiry in the same cycle.
          if (bus_io.mds_out_valid) begin
            rsp_data_q  <= bus_io.mds_out;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= owner_q ? 2'b10 : 2'b01;
            state_q     <= StResp;
          end else if (timeout_hit) begin
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= owner_q ? 2'b10 : 2'b01;
            state_q     <= StResp;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StResp: begin
          if (bus_io.rsp_ready[owner_q]) begin
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus_io.req_ready    = req_ready;
  assign bus_io.rsp_valid    = rsp_valid_q;
  assign bus_io.rsp_data     = rsp_data_q;
  assign bus_io.rsp_err      = rsp_err_q;
  assign bus_io.mds_in_a     = in_a_q;
  assign bus_io.mds_in_b     = in_b_q;
  assign bus_io.mds_op       = op_q;
  assign bus_io.mds_in_valid = in_valid_q;

endmodule
